// File: rtl/cvxif_regs_ctrl_pkg.sv
// Shared types and default sizing for the CV-X-IF register bank and its load sequencer.
package cvxif_regs_ctrl_pkg;

  localparam int NB_OF_REGS_DEF = 150;
  localparam int REG_WIDTH_DEF  = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FULL,
    RUN,
    CLEAR
  } ctrl_state_e;

endpackage

// File: rtl/cvxif_regs_load_ctrl.sv
// Load sequencer for the CV-X-IF register bank: fills it over valid/ready, launches the consumer, dumps on done/abort.
// Write path has 1-cycle latency; in_ready_o drops combinationally on clear_i and whenever the bank is full or busy.
module cvxif_regs_load_ctrl
  import cvxif_regs_ctrl_pkg::*;
#(
  parameter int NB_OF_REGS = NB_OF_REGS_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int CNT_WIDTH  = $clog2(NB_OF_REGS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic [REG_WIDTH-1:0] in_data_i,
  output logic                 in_ready_o,
  input  logic                 run_i,
  input  logic                 done_i,
  output logic                 regs_we_o,
  output logic [REG_WIDTH-1:0] regs_data_o,
  output logic                 regs_dump_o,
  output logic                 start_o,
  output logic                 abort_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(NB_OF_REGS);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NB_OF_REGS - 1);

  ctrl_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   we_q, we_d;
  logic [REG_WIDTH-1:0]   data_q, data_d;
  logic                   start_q, start_d;
  logic                   abort_q, abort_d;
  logic                   err_q, err_d;
  logic                   accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clear_i wins over every other request except while already clearing.
  always_comb begin
    state_d = state_q;
    if (clear_i && state_q != CLEAR) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (count_q == CNT_LAST) ? FULL : LOAD;
        LOAD:    if (accept && count_q == CNT_LAST) state_d = FULL;
        FULL:    if (run_i) state_d = RUN;
        RUN:     if (done_i) state_d = CLEAR;
        CLEAR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE || state_q == LOAD) && !clear_i;
    busy_o      = (state_q == RUN);
    regs_dump_o = (state_q == CLEAR);
  end

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    count_d = count_q;
    if (state_q == CLEAR) begin
      count_d = '0;
    end else if (accept && count_q != CNT_MAX) begin
      count_d = count_q + CNT_WIDTH'(1);
    end

    we_d    = accept;
    data_d  = accept ? in_data_i : data_q;
    start_d = (state_q == FULL) && run_i && !clear_i;
    abort_d = (state_q == RUN) && clear_i;

    // The dump cycle wipes the error flag, even if run_i arrives during it.
    if (state_q == CLEAR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q || (run_i && !clear_i && state_q != FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      we_q    <= we_d;
      data_q  <= data_d;
      start_q <= start_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign regs_we_o   = we_q;
  assign regs_data_o = data_q;
  assign start_o     = start_q;
  assign abort_o     = abort_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_MAX);
  assign err_o       = err_q;

endmodule

// File: tb/tb_cvxif_regs_load_ctrl.sv
// Bench for cvxif_regs_load_ctrl at NB_OF_REGS=4: directed table, async-reset sequence, random run vs. queue model.
module tb_cvxif_regs_load_ctrl;

  localparam int NB = 4;
  localparam int W  = 9;
  localparam int CW = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          vld = 1'b0;
  logic [W-1:0]  din = '0;
  logic          run = 1'b0;
  logic          done = 1'b0;
  logic          rdy, we, dump, start, abort, full, busy, err;
  logic [W-1:0]  data;
  logic [CW-1:0] cnt;

  cvxif_regs_load_ctrl #(.NB_OF_REGS(NB), .REG_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(vld), .in_data_i(din), .in_ready_o(rdy),
    .run_i(run), .done_i(done),
    .regs_we_o(we), .regs_data_o(data), .regs_dump_o(dump),
    .start_o(start), .abort_o(abort), .count_o(cnt),
    .full_o(full), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          full, rdy, start, busy, dump, abort, err;
  } outs_t;

  typedef struct {
    logic         c, v;
    logic [W-1:0] d;
    logic         r, dn;
    outs_t        e;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input outs_t e);
    chk({tag, ".we"},    32'(we),    32'(e.we));
    chk({tag, ".data"},  32'(data),  32'(e.data));
    chk({tag, ".count"}, 32'(cnt),   32'(e.cnt));
    chk({tag, ".full"},  32'(full),  32'(e.full));
    chk({tag, ".ready"}, 32'(rdy),   32'(e.rdy));
    chk({tag, ".start"}, 32'(start), 32'(e.start));
    chk({tag, ".busy"},  32'(busy),  32'(e.busy));
    chk({tag, ".dump"},  32'(dump),  32'(e.dump));
    chk({tag, ".abort"}, 32'(abort), 32'(e.abort));
    chk({tag, ".err"},   32'(err),   32'(e.err));
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, ".we"},    32'(we),    32'd0);
    chk({tag, ".data"},  32'(data),  32'd0);
    chk({tag, ".count"}, 32'(cnt),   32'd0);
    chk({tag, ".full"},  32'(full),  32'd0);
    chk({tag, ".start"}, 32'(start), 32'd0);
    chk({tag, ".busy"},  32'(busy),  32'd0);
    chk({tag, ".dump"},  32'(dump),  32'd0);
    chk({tag, ".abort"}, 32'(abort), 32'd0);
    chk({tag, ".err"},   32'(err),   32'd0);
  endtask

  function automatic vec_t mk(input logic c, input logic v, input logic [W-1:0] d,
                              input logic r, input logic dn,
                              input logic e_we, input logic [W-1:0] e_data, input logic [CW-1:0] e_cnt,
                              input logic e_full, input logic e_rdy, input logic e_start,
                              input logic e_busy, input logic e_dump, input logic e_abort,
                              input logic e_err);
    vec_t t;
    t.c = c; t.v = v; t.d = d; t.r = r; t.dn = dn;
    t.e.we = e_we; t.e.data = e_data; t.e.cnt = e_cnt; t.e.full = e_full; t.e.rdy = e_rdy;
    t.e.start = e_start; t.e.busy = e_busy; t.e.dump = e_dump; t.e.abort = e_abort; t.e.err = e_err;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    clear = t.c; vld = t.v; din = t.d; run = t.r; done = t.dn;
    @(posedge clk);
    #1;
    check_all(tag, t.e);
  endtask

  // Reference model: the bank is a queue of words plus run/dump/err flags.
  logic [W-1:0] m_q[$];
  logic         m_run, m_dump, m_err, m_we, m_start, m_abort;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_run = 0; m_dump = 0; m_err = 0; m_we = 0; m_start = 0; m_abort = 0; m_data = '0;
  endtask

  task automatic model_step(input logic c, input logic v, input logic [W-1:0] d,
                            input logic r, input logic dn);
    logic o_run, o_dump, o_full, acc;
    o_run  = m_run;
    o_dump = m_dump;
    o_full = (m_q.size() == NB);
    acc    = !o_run && !o_dump && !o_full && !c && v;
    m_we    = acc;
    m_start = 0;
    m_abort = 0;
    if (acc) begin
      m_data = d;
      m_q.push_back(d);
    end
    if (o_dump) begin
      m_q.delete();
      m_err  = 0;
      m_dump = 0;
    end else if (c) begin
      m_dump  = 1;
      m_abort = o_run;
      m_run   = 0;
    end else begin
      if (r) begin
        if (o_full && !o_run) begin
          m_run   = 1;
          m_start = 1;
        end else begin
          m_err = 1;
        end
      end
      if (o_run && dn) begin
        m_run  = 0;
        m_dump = 1;
      end
    end
  endtask

  function automatic outs_t model_outs(input logic c);
    outs_t o;
    o.we    = m_we;
    o.data  = m_data;
    o.cnt   = CW'(m_q.size());
    o.full  = (m_q.size() == NB);
    o.rdy   = !m_run && !m_dump && (m_q.size() < NB) && !c;
    o.start = m_start;
    o.busy  = m_run;
    o.dump  = m_dump;
    o.abort = m_abort;
    o.err   = m_err;
    return o;
  endfunction

  initial begin
    vec_t tbl[$];

    // Fill with 0x011..0x014
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,1,W'(9'h011 + i),0,0, 1,W'(9'h011 + i),CW'(i + 1),(i == 3),(i != 3),0,0,0,0,0));
    // Pushing into a full bank
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,9'h1AA,0,0, 0,9'h014,3'd4,1,0,0,0,0,0,0));
    // Run, done two cycles later, one dump cycle, back to IDLE
    tbl.push_back(mk(0,0,9'h000,1,0, 0,9'h014,3'd4,1,0,1,1,0,0,0));
    tbl.push_back(mk(0,0,9'h000,0,0, 0,9'h014,3'd4,1,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,9'h000,0,1, 0,9'h014,3'd4,1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,9'h000,0,0, 0,9'h014,3'd0,0,1,0,0,0,0,0));
    // Run on a half-filled bank, then clear
    tbl.push_back(mk(0,1,9'h021,0,0, 1,9'h021,3'd1,0,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,9'h022,0,0, 1,9'h022,3'd2,0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,9'h000,1,0, 0,9'h022,3'd2,0,1,0,0,0,0,1));
    tbl.push_back(mk(0,0,9'h000,0,0, 0,9'h022,3'd2,0,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,9'h000,0,0, 0,9'h022,3'd2,0,0,0,0,1,0,1));
    tbl.push_back(mk(0,0,9'h000,0,0, 0,9'h022,3'd0,0,1,0,0,0,0,0));
    // Abort: clear and done together while running
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,1,W'(9'h031 + i),0,0, 1,W'(9'h031 + i),CW'(i + 1),(i == 3),(i != 3),0,0,0,0,0));
    tbl.push_back(mk(0,0,9'h000,1,0, 0,9'h034,3'd4,1,0,1,1,0,0,0));
    tbl.push_back(mk(1,0,9'h000,0,1, 0,9'h034,3'd4,1,0,0,0,1,1,0));
    tbl.push_back(mk(0,0,9'h000,0,0, 0,9'h034,3'd0,0,1,0,0,0,0,0));

    #2;
    check_reset_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 3; i++)
      apply(mk(0,1,W'(9'h041 + i),0,0, 1,W'(9'h041 + i),CW'(i + 1),0,1,0,0,0,0,0), $sformatf("arst_fill%0d", i));
    @(negedge clk);
    clear = 0; vld = 0; run = 0; done = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_zero("arst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0,1,9'h055,0,0, 1,9'h055,3'd1,0,1,0,0,0,0,0), "arst_after");

    // Random traffic against the model
    @(negedge clk);
    clear = 0; vld = 0; run = 0; done = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 99) < 4);
      vld   = ($urandom_range(0, 99) < 65);
      din   = W'($urandom_range(0, 511));
      run   = ($urandom_range(0, 99) < 12);
      done  = ($urandom_range(0, 99) < 20);
      @(posedge clk);
      model_step(clear, vld, din, run, done);
      #1;
      check_all($sformatf("rnd%0d", n), model_outs(clear));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
